control_decodificador: RTL and testbench
========================================

# control_decodificador

Sequencing controller for the SECDED Hamming(8,4) receive path. It accepts received 8-bit words over a valid/ready handshake and computes and registers the 4-bit error position. It drives the external correction datapath, captures the corrected 4-bit word and double-error flag, and holds the result until the consumer (display/LED stage) accepts it. It also keeps saturating counters of single and double errors for board-level reporting.

## Interface
- `CNT_W`, default 8: width of each error counter.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous and active-low
- `in_valid`  in  1  a received word is presented
- `in_ready`  out  1  controller can accept a word
- `conmutador_8`  in  8  received word; bit order is g0,w3,w2,w1,p2,w0,p1,p0 (bits 7 down to 0)
- `palabra_o`  out  8  registered word sent to the correction datapath
- `pos_error_o`  out  4  registered error position {eg,e2,e1,e0} sent to the correction datapath
- `w_corregida_b4`  in  5  datapath result {double flag, w3,w2,w1,w0}; combinational from `palabra_o`/`pos_error_o`
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `dato_o`  out  4  corrected data w3..w0
- `doble_error_o`  out  1  1 = uncorrectable double error
- `clr_cnt`  in  1  synchronous clear of both counters
- `cnt_simple`  out  CNT_W  count of single errors, including global-bit errors
- `cnt_doble`  out  CNT_W  count of double errors

## Operation
- **FSM states and transitions:**
  - IDLE → SINDROME on `in_valid && in_ready`.
  - SINDROME → CORREGIR unconditionally.
  - CORREGIR → ENTREGA unconditionally.
  - ENTREGA → IDLE on `out_valid && out_ready`.
- `in_ready` = 1 only in IDLE. `out_valid` = 1 only in ENTREGA.
- **Accept:** register `conmutador_8` into `palabra_o`.
- **SINDROME:** compute from `palabra_o` (bit index b0..b7) and register into `pos_error_o`:
  - e0 = b0^b2^b4^b6
  - e1 = b1^b2^b5^b6
  - e2 = b3^b4^b5^b6
  - eg = XOR of all 8 bits
- **Classification:**
  - 0000 → no error.
  - eg=1 → single error; position {e2,e1,e0}, where 000 means the global bit.
  - eg=0 with nonzero syndrome → double error.
- **CORREGIR:**
  - Capture `w_corregida_b4[3:0]` into `dato_o` and `w_corregida_b4[4]` into `doble_error_o`.
  - Increment `cnt_simple` if eg=1; increment `cnt_doble` if the error is a double.
- **Counters:**
  - Saturate at 2^CNT_W−1; no wrap.
  - `clr_cnt` wins over a simultaneous increment.
  - `clr_cnt` is accepted in any state.
- `dato_o` and `doble_error_o` hold their last value outside ENTREGA. `palabra_o` and `pos_error_o` hold until the next accept.

## Timing
- **Reset values:**
  - State = IDLE, so `in_ready`=1 and `out_valid`=0.
  - `palabra_o`, `pos_error_o`, `dato_o`, `doble_error_o`, `cnt_simple`, `cnt_doble` = 0.
- **Latency:** word accepted in cycle T gives `out_valid`=1 in T+3.
  - `pos_error_o` is valid from T+2.
  - `w_corregida_b4` is sampled at the end of T+2.
- **Backpressure:**
  - ENTREGA holds `out_valid`, `dato_o` and `doble_error_o` stable until `out_ready`.
  - `in_ready` returns to 1 the cycle after the output handshake.
- **Throughput:** one word per 4 cycles minimum. There is no overlap; `in_valid` is ignored outside IDLE.
- `out_ready` asserted before `out_valid` has no effect.
- **Reset mid-operation:** any state returns to IDLE immediately. In-flight data and counters clear, and no partial result is emitted.

## Structure
- **Package `decodificador_pkg`:**
  - State enum `estado_t` (IDLE, SINDROME, CORREGIR, ENTREGA).
  - Constants POS_SIN_ERROR = 4'b0000 and POS_GLOBAL = 4'b1000.
  - Bit-index localparams for g0/w3/w2/w1/p2/w0/p1/p0.
- **Sub-module `sindrome_hamming`:** purely combinational, 8-bit word in → 4-bit {eg,e2,e1,e0} out. Instantiated once; reusable by the transmit-side checker.
- The correction datapath stays external; this block only drives it and samples it.

## Test plan
- **Clean word:** accept 0x55 → `pos_error_o`=0000 at T+2; `out_valid` at T+3 with `dato_o`=1011, `doble_error_o`=0; counters unchanged.
- **Single data error:** 0x45 (w1 flipped) → `pos_error_o`=1101, `dato_o`=1011, `cnt_simple`=1. Then 0xD5 (g0 flipped) → `pos_error_o`=1000, `dato_o`=1011, `cnt_simple`=2.
- **Double error:** 0x44 → `pos_error_o`=0100, `doble_error_o`=1, `dato_o`=0000, `cnt_doble`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles → `out_valid` and `dato_o` stable. While held, `in_valid`=1 with 0x00 is not accepted (`in_ready`=0). Releasing `out_ready` gives `in_ready`=1 next cycle.
- **Saturation and clear (CNT_W=2):** five single-error words → `cnt_simple`=3. Then `clr_cnt` asserted in the same cycle as a CORREGIR increment → `cnt_simple`=0.
- **Reset mid-operation:** deassert `rst_n` in CORREGIR → all outputs at reset values, and no `out_valid` pulse after release.

Source files
------------

// File: rtl/decodificador_pkg.sv
// Shared types and constants for the SECDED Hamming(8,4) receive-path controller.
package decodificador_pkg;

    localparam int unsigned PALABRA_W = 8;
    localparam int unsigned POS_W     = 4;
    localparam int unsigned DATO_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SINDROME = 2'd1,
        CORREGIR = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

    localparam logic [POS_W-1:0] POS_SIN_ERROR = 4'b0000;
    localparam logic [POS_W-1:0] POS_GLOBAL    = 4'b1000;

    // Bit positions inside the received word (g0,w3,w2,w1,p2,w0,p1,p0).
    localparam int unsigned BIT_P0 = 0;
    localparam int unsigned BIT_P1 = 1;
    localparam int unsigned BIT_W0 = 2;
    localparam int unsigned BIT_P2 = 3;
    localparam int unsigned BIT_W1 = 4;
    localparam int unsigned BIT_W2 = 5;
    localparam int unsigned BIT_W3 = 6;
    localparam int unsigned BIT_G0 = 7;

    // Index of the global-parity flag inside the error position.
    localparam int unsigned POS_EG = 3;

endpackage

// File: rtl/sindrome_hamming.sv
// Combinational SECDED syndrome: 8-bit received word in, {eg,e2,e1,e0} out.
module sindrome_hamming
    import decodificador_pkg::*;
(
    input  logic [PALABRA_W-1:0] palabra,
    output logic [POS_W-1:0]     sindrome_c
);

    always_comb begin
        sindrome_c    = POS_SIN_ERROR;
        sindrome_c[0] = palabra[BIT_P0] ^ palabra[BIT_W0] ^ palabra[BIT_W1] ^ palabra[BIT_W3];
        sindrome_c[1] = palabra[BIT_P1] ^ palabra[BIT_W0] ^ palabra[BIT_W2] ^ palabra[BIT_W3];
        sindrome_c[2] = palabra[BIT_P2] ^ palabra[BIT_W1] ^ palabra[BIT_W2] ^ palabra[BIT_W3];
        sindrome_c[POS_EG] = ^palabra;
    end

endmodule

// File: rtl/control_decodificador.sv
// Sequencing controller for the Hamming(8,4) receive path: accept, syndrome,
// sample the external correction datapath, hand off the result, count errors.
module control_decodificador
    import decodificador_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PALABRA_W-1:0] conmutador_8,
    output logic [PALABRA_W-1:0] palabra_o,
    output logic [POS_W-1:0]     pos_error_o,
    input  logic [DATO_W:0]      w_corregida_b4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATO_W-1:0]    dato_o,
    output logic                 doble_error_o,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     cnt_simple,
    output logic [CNT_W-1:0]     cnt_doble
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    estado_t          estado;
    logic [POS_W-1:0] sindrome_c;
    logic             es_simple_c;
    logic             es_doble_c;

    sindrome_hamming u_sindrome (
        .palabra    (palabra_o),
        .sindrome_c (sindrome_c)
    );

    // Classification of the registered error position.
    assign es_simple_c = pos_error_o[POS_EG];
    assign es_doble_c  = !pos_error_o[POS_EG] && (pos_error_o[2:0] != 3'b000);

    // Sequencer with registered handshake outputs and captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            palabra_o     <= '0;
            pos_error_o   <= POS_SIN_ERROR;
            dato_o        <= '0;
            doble_error_o <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        palabra_o <= conmutador_8;
                        in_ready  <= 1'b0;
                        estado    <= SINDROME;
                    end
                end
                SINDROME: begin
                    pos_error_o <= sindrome_c;
                    estado      <= CORREGIR;
                end
                CORREGIR: begin
                    dato_o        <= w_corregida_b4[DATO_W-1:0];
                    doble_error_o <= w_corregida_b4[DATO_W];
                    out_valid     <= 1'b1;
                    estado        <= ENTREGA;
                end
                ENTREGA: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        estado    <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    estado    <= IDLE;
                end
            endcase
        end
    end

    // Saturating error counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_simple <= '0;
            cnt_doble  <= '0;
        end else if (clr_cnt) begin
            cnt_simple <= '0;
            cnt_doble  <= '0;
        end else if (estado == CORREGIR) begin
            if (es_simple_c && (cnt_simple != CNT_MAX)) begin
                cnt_simple <= cnt_simple + CNT_W'(1);
            end
            if (es_doble_c && (cnt_doble != CNT_MAX)) begin
                cnt_doble <= cnt_doble + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_decodificador.sv
// Self-checking bench for control_decodificador with an external datapath stub.
module tb_control_decodificador;

    localparam int unsigned CNT_W = 2;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       conmutador_8 = 8'h00;
    logic [7:0]       palabra_o;
    logic [3:0]       pos_error_o;
    logic [4:0]       w_corregida_b4;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       dato_o;
    logic             doble_error_o;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] cnt_simple;
    logic [CNT_W-1:0] cnt_doble;

    int total = 0;
    int bad = 0;
    int m_simple = 0;
    int m_doble = 0;

    control_decodificador #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .conmutador_8   (conmutador_8),
        .palabra_o      (palabra_o),
        .pos_error_o    (pos_error_o),
        .w_corregida_b4 (w_corregida_b4),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dato_o         (dato_o),
        .doble_error_o  (doble_error_o),
        .clr_cnt        (clr_cnt),
        .cnt_simple     (cnt_simple),
        .cnt_doble      (cnt_doble)
    );

    always #5 clk = ~clk;

    // External correction datapath: flip the flagged bit, zero data on a double error.
    always_comb begin
        logic [7:0] fix;
        fix = palabra_o;
        w_corregida_b4 = 5'b0;
        if (!pos_error_o[3] && pos_error_o[2:0] != 3'b000) begin
            w_corregida_b4 = 5'b10000;
        end else begin
            if (pos_error_o[3] && pos_error_o[2:0] != 3'b000)
                fix[pos_error_o[2:0] - 3'd1] = ~fix[pos_error_o[2:0] - 3'd1];
            w_corregida_b4 = {1'b0, fix[6], fix[5], fix[4], fix[2]};
        end
    end

    // Reference: syndrome is the XOR of the 1-based Hamming positions of set bits.
    function automatic logic [3:0] ref_pos(input logic [7:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 7; i++) if (w[i]) s = s ^ (i + 1);
        return {^w, 3'(s)};
    endfunction

    function automatic logic [3:0] ref_data(input logic [7:0] w);
        logic [3:0] p;
        logic [7:0] c;
        p = ref_pos(w);
        c = w;
        if (!p[3] && p[2:0] != 0) return 4'b0000;
        if (p[3] && p[2:0] != 0) c[int'(p[2:0]) - 1] = ~c[int'(p[2:0]) - 1];
        return {c[6], c[5], c[4], c[2]};
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] w;
        logic [3:0] p;
        w = 8'h00;
        w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
        p = ref_pos(w);
        w[0] = p[0]; w[1] = p[1]; w[3] = p[2];
        w[7] = ^w[6:0];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with optional backpressure, early ready and clear-in-CORREGIR.
    task automatic send(input logic [7:0] w, input int hold, input bit early, input bit clr_corr);
        logic [3:0] ep;
        logic [3:0] ed;
        bit         dbl;
        ep  = ref_pos(w);
        ed  = ref_data(w);
        dbl = !ep[3] && (ep[2:0] != 0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        conmutador_8 = w;
        step();
        in_valid = 1'b0;
        conmutador_8 = 8'h00;
        if (early) out_ready = 1'b1;
        chk("palabra", 32'(palabra_o), 32'(w));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        step();
        chk("pos_error", 32'(pos_error_o), 32'(ep));
        chk("out_valid_early", 32'(out_valid), 32'd0);
        if (clr_corr) clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        if (clr_corr) begin
            m_simple = 0;
            m_doble  = 0;
        end else begin
            if (ep[3] && m_simple < CMAX) m_simple++;
            if (dbl && m_doble < CMAX) m_doble++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("dato", 32'(dato_o), 32'(ed));
        chk("doble", 32'(doble_error_o), 32'(dbl));
        chk("cnt_simple", 32'(cnt_simple), 32'(m_simple));
        chk("cnt_doble", 32'(cnt_doble), 32'(m_doble));
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                conmutador_8 = 8'h00;
                step();
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_dato", 32'({doble_error_o, dato_o}), 32'({dbl, ed}));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                chk("hold_palabra", 32'(palabra_o), 32'(w));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        step();
        out_ready = 1'b0;
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("out_valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_regs", 32'({palabra_o, pos_error_o, dato_o, doble_error_o}), 32'd0);
        chk("rst_cnts", 32'({cnt_simple, cnt_doble}), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        send(8'h55, 0, 1'b0, 1'b0);
        send(8'h45, 0, 1'b0, 1'b0);
        send(8'hD5, 0, 1'b0, 1'b0);
        send(8'h44, 10, 1'b0, 1'b0);
        send(8'h55, 2, 1'b1, 1'b0);

        // Clear, then saturate the single-error counter.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        m_simple = 0;
        m_doble  = 0;
        chk("clr_idle", 32'({cnt_simple, cnt_doble}), 32'd0);
        for (int i = 0; i < 5; i++) send(8'h45, 0, 1'b0, 1'b0);
        chk("sat_simple", 32'(cnt_simple), 32'd3);
        send(8'hD5, 0, 1'b0, 1'b1);
        chk("clr_wins", 32'(cnt_simple), 32'd0);

        // Reset while in CORREGIR.
        send(8'h45, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
        conmutador_8 = 8'h44;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        m_simple = 0;
        m_doble  = 0;
        chk("mid_rst_hs", 32'({in_ready, out_valid}), 32'b10);
        chk("mid_rst_regs", 32'({palabra_o, pos_error_o, dato_o, doble_error_o}), 32'd0);
        chk("mid_rst_cnts", 32'({cnt_simple, cnt_doble}), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_pulse", 32'({in_ready, out_valid}), 32'b10);
        end

        // Randomized codewords with 0, 1 or 2 injected bit errors.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] w;
            int nf, b1, b2;
            w  = encode(4'($urandom_range(0, 15)));
            nf = $urandom_range(0, 2);
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            if (nf >= 1) w[b1] = ~w[b1];
            if (nf == 2) w[b2] = ~w[b2];
            if ($urandom_range(0, 9) == 0) begin
                clr_cnt = 1'b1;
                step();
                clr_cnt = 1'b0;
                m_simple = 0;
                m_doble  = 0;
            end
            send(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
